// File: rtl/line_buffer_5x5_if.sv
// Pixel stream in, five vertically aligned taps out, between the line buffer
// and its neighbours. The slave side is the line buffer itself.
interface line_buffer_5x5_if #(
  parameter int DATA_W = 8
);
  logic              done_i;
  logic [DATA_W-1:0] data_i;
  logic [DATA_W-1:0] S1_o;
  logic [DATA_W-1:0] S2_o;
  logic [DATA_W-1:0] S3_o;
  logic [DATA_W-1:0] S4_o;
  logic [DATA_W-1:0] S5_o;
  logic              done_o;
  logic              frame_done_o;

  modport master (
    output done_i, data_i,
    input  S1_o, S2_o, S3_o, S4_o, S5_o, done_o, frame_done_o
  );

  modport slave (
    input  done_i, data_i,
    output S1_o, S2_o, S3_o, S4_o, S5_o, done_o, frame_done_o
  );
endinterface

// File: rtl/line_buffer_5x5.sv
// Four-row line buffer feeding a 5x5 window. Every accepted raster pixel is
// emitted together with the four pixels directly above it (oldest row on S1).
// The row memories form a vertical shift chain indexed by the column pointer,
// so each column slot ages by one row per accepted pixel in that column.
module line_buffer_5x5 #(
  parameter int COLS   = 7,
  parameter int ROWS   = 7,
  parameter int DATA_W = 8
) (
  input logic               clk,
  input logic               rst,
  line_buffer_5x5_if.slave  bus
);

  localparam int CW = (COLS > 2) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 2) ? $clog2(ROWS) : 1;

  // Row memories: index 0 is the most recent row, 3 the oldest.
  logic [DATA_W-1:0] mem_q [4][COLS];
  logic [DATA_W-1:0] mem_d [4][COLS];

  // Tap registers: index 0 drives S1 (oldest), index 4 drives S5 (current).
  logic [DATA_W-1:0] taps_p1_q [5];
  logic [DATA_W-1:0] taps_p1_d [5];

  logic          vld_p1_q, vld_p1_d;
  logic          frame_done_p1_q, frame_done_p1_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic col_last;
  logic row_last;

  assign col_last = (col_q == CW'(COLS - 1));
  assign row_last = (row_q == RW'(ROWS - 1));

  // Next-state: read-before-write shift of the addressed column, tap capture,
  // valid/frame-end qualification and raster position advance.
  always_comb begin
    mem_d           = mem_q;
    taps_p1_d       = taps_p1_q;
    col_d           = col_q;
    row_d           = row_q;
    vld_p1_d        = 1'b0;
    frame_done_p1_d = 1'b0;
    if (bus.done_i) begin
      taps_p1_d[4] = bus.data_i;
      taps_p1_d[3] = mem_q[0][col_q];
      taps_p1_d[2] = mem_q[1][col_q];
      taps_p1_d[1] = mem_q[2][col_q];
      taps_p1_d[0] = mem_q[3][col_q];

      mem_d[0][col_q] = bus.data_i;
      mem_d[1][col_q] = mem_q[0][col_q];
      mem_d[2][col_q] = mem_q[1][col_q];
      mem_d[3][col_q] = mem_q[2][col_q];

      // Rows 0..3 only prime the memories; their taps hold stale data.
      vld_p1_d        = (row_q >= RW'(4));
      frame_done_p1_d = col_last && row_last;

      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // ---- stage p0 -> p1 boundary ----
  // State and output registers; reset clears everything including the memories.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < 4; l++) begin
        for (int c = 0; c < COLS; c++) begin
          mem_q[l][c] <= '0;
        end
      end
      for (int t = 0; t < 5; t++) begin
        taps_p1_q[t] <= '0;
      end
      vld_p1_q        <= 1'b0;
      frame_done_p1_q <= 1'b0;
      col_q           <= '0;
      row_q           <= '0;
    end else begin
      mem_q           <= mem_d;
      taps_p1_q       <= taps_p1_d;
      vld_p1_q        <= vld_p1_d;
      frame_done_p1_q <= frame_done_p1_d;
      col_q           <= col_d;
      row_q           <= row_d;
    end
  end

  assign bus.S1_o         = taps_p1_q[0];
  assign bus.S2_o         = taps_p1_q[1];
  assign bus.S3_o         = taps_p1_q[2];
  assign bus.S4_o         = taps_p1_q[3];
  assign bus.S5_o         = taps_p1_q[4];
  assign bus.done_o       = vld_p1_q;
  assign bus.frame_done_o = frame_done_p1_q;

endmodule

// File: tb/tb_line_buffer_5x5.sv
// Directed bench for line_buffer_5x5 (7x7 frames). Expected taps come from the
// pixel formula base + row*16 + col, looking back into the previous frame (or
// zero after reset) for rows that are not yet filled in the current frame.
module tb_line_buffer_5x5;

  localparam int COLS = 7;
  localparam int ROWS = 7;

  logic clk;
  logic rst;

  line_buffer_5x5_if #(.DATA_W(8)) bus ();

  line_buffer_5x5 #(.COLS(COLS), .ROWS(ROWS), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] taps_now();
    return {bus.S1_o, bus.S2_o, bus.S3_o, bus.S4_o, bus.S5_o};
  endfunction

  // Expected {S1..S5} for pixel (r,c); prev < 0 means memories were cleared.
  function automatic logic [39:0] exp_taps(input int base, input int prev, input int r, input int c);
    logic [39:0] t;
    int rr;
    int v;
    t = '0;
    for (int k = 0; k < 5; k++) begin
      rr = r - (4 - k);
      if (rr >= 0)        v = base + rr * 16 + c;
      else if (prev >= 0) v = prev + (ROWS + rr) * 16 + c;
      else                v = 0;
      t[(4 - k) * 8 +: 8] = v[7:0];
    end
    return t;
  endfunction

  task automatic step(input logic v, input logic [7:0] d);
    bus.done_i = v;
    bus.data_i = d;
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges while a pixel is being offered.
  task automatic async_reset(input string tag);
    bus.done_i = 1'b1;
    bus.data_i = 8'hEE;
    #2;
    rst = 1'b1;
    #1;
    chk_eq({tag, "_outs"}, {24'd0, taps_now(), bus.done_o, bus.frame_done_o}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.done_i = 1'b0;
  endtask

  task automatic run_frame(input int base, input int prev, input bit gap, input int npix, input string tag);
    int strobes;
    int first;
    int idx;
    logic [39:0] e;
    strobes = 0;
    first   = -1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        idx = r * COLS + c;
        if (idx < npix) begin
          step(1'b1, 8'(base + r * 16 + c));
          e = exp_taps(base, prev, r, c);
          chk_eq({tag, "_vld"}, 64'(bus.done_o), 64'(r >= 4));
          chk_eq({tag, "_fdone"}, 64'(bus.frame_done_o), 64'((r == ROWS - 1) && (c == COLS - 1)));
          chk_eq({tag, "_taps"}, 64'(taps_now()), 64'(e));
          if (bus.done_o) begin
            strobes++;
            if (first < 0) first = idx;
          end
          if (gap) begin
            step(1'b0, 8'h5A);
            chk_eq({tag, "_idle_vld"}, 64'(bus.done_o), 64'd0);
            chk_eq({tag, "_idle_fdone"}, 64'(bus.frame_done_o), 64'd0);
            chk_eq({tag, "_idle_hold"}, 64'(taps_now()), 64'(e));
          end
        end
      end
    end
    if (npix == ROWS * COLS) begin
      chk_eq({tag, "_strobes"}, 64'(strobes), 64'd21);
      chk_eq({tag, "_first"}, 64'(first), 64'd28);
    end
  endtask

  initial begin
    rst        = 1'b1;
    bus.done_i = 1'b0;
    bus.data_i = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("reset_outs", {24'd0, taps_now(), bus.done_o, bus.frame_done_o}, 64'd0);
    rst = 1'b0;

    // Partial stream, then reset in the middle of it.
    run_frame(8'h30, -1, 1'b0, 10, "pre");
    async_reset("rst_mid");

    // Frame 1: clean memories, continuous input; hand-computed spot checks.
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        step(1'b1, 8'(r * 16 + c));
        if (r == 4 && c == 2) begin
          chk_eq("f1_r4c2_taps", 64'(taps_now()), 64'h02_12_22_32_42);
          chk_eq("f1_r4c2_vld", 64'(bus.done_o), 64'd1);
        end
        if (r == 3 && c == 6) chk_eq("f1_r3c6_vld", 64'(bus.done_o), 64'd0);
        if (r == 6 && c == 6) begin
          chk_eq("f1_last_taps", 64'(taps_now()), 64'h26_36_46_56_66);
          chk_eq("f1_last_vld", 64'(bus.done_o), 64'd1);
          chk_eq("f1_last_fdone", 64'(bus.frame_done_o), 64'd1);
        end
      end
    end
    step(1'b0, 8'h00);
    chk_eq("f1_after_fdone", 64'(bus.frame_done_o), 64'd0);

    // Frame 2: same pixels with an idle cycle after every pixel.
    run_frame(8'h00, 8'h00, 1'b1, ROWS * COLS, "f2_gap");

    // Frame 3: streamed back-to-back, stale frame-2 data must not leak out.
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        step(1'b1, 8'(8'h80 + r * 16 + c));
        if (r < 4) chk_eq("f3_fill_vld", 64'(bus.done_o), 64'd0);
        if (r == 4 && c == 0) begin
          chk_eq("f3_r4c0_taps", 64'(taps_now()), 64'h80_90_A0_B0_C0);
          chk_eq("f3_r4c0_vld", 64'(bus.done_o), 64'd1);
        end
      end
    end

    // Frame 4: full model check, continuing directly after frame 3.
    run_frame(8'h40, 8'h80, 1'b0, ROWS * COLS, "f4");

    // Frame 5 interrupted in row 5, then a fresh frame after reset.
    run_frame(8'h20, 8'h40, 1'b0, 5 * COLS + 3, "f5_part");
    async_reset("rst_row5");
    run_frame(8'h10, -1, 1'b0, ROWS * COLS, "f6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
